// File: rtl/count_cmd_scheduler_if.sv
// rtl/count_cmd_scheduler_if.sv - requester command ports and counter status bundle
//
// Purpose: groups the two requester valid/ready command ports and the shared
// counter status outputs of count_cmd_scheduler into one bundle.
// Signals:
//   req0_valid/req0_ready/req0_op/req0_arg  requester 0 command port
//   req1_valid/req1_ready/req1_op/req1_arg  requester 1 command port
//   op encoding: 00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
//   count       current register value
//   busy        high while a command is executing or completing
//   done_valid  one-cycle completion strobe
//   done_id     requester id of the completed command
// Modports:
//   master  requester side (drives commands, observes status)
//   slave   scheduler side
interface count_cmd_scheduler_if #(
    parameter int WIDTH = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_arg;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_arg;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done_valid;
    logic             done_id;

    modport master (
        output req0_valid, req0_op, req0_arg,
        output req1_valid, req1_op, req1_arg,
        input  req0_ready, req1_ready,
        input  count, busy, done_valid, done_id
    );

    modport slave (
        input  req0_valid, req0_op, req0_arg,
        input  req1_valid, req1_op, req1_arg,
        output req0_ready, req1_ready,
        output count, busy, done_valid, done_id
    );
endinterface

// File: rtl/count_cmd_scheduler.sv
// rtl/count_cmd_scheduler.sv - two-requester round-robin scheduler for a shared up/down count register
//
// Purpose: arbitrates LOAD/UP/DOWN/CLEAR commands from two requesters and
// executes them one at a time on an internal WIDTH-bit count register.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   count_cmd_scheduler_if.slave (command ports, count, busy, done strobe)
module count_cmd_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    count_cmd_scheduler_if.slave   bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] rem_q, rem_d;       // LOAD value or remaining UP/DOWN steps
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             done_valid_q, done_valid_d;
    logic             done_id_q, done_id_d;

    logic             grant0, grant1;
    logic             ready0, ready1;

    // On a tie the requester that did not win last time gets the grant.
    always_comb begin
        grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
        grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
        ready0 = grant0 & (state_q == ST_IDLE);
        ready1 = grant1 & (state_q == ST_IDLE);
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rem_d        = rem_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;

        case (state_q)
            ST_IDLE: begin
                if (ready0) begin
                    op_d         = bus.req0_op;
                    rem_d        = bus.req0_arg;
                    id_d         = 1'b0;
                    last_grant_d = 1'b0;
                    state_d      = ST_EXEC;
                end else if (ready1) begin
                    op_d         = bus.req1_op;
                    rem_d        = bus.req1_arg;
                    id_d         = 1'b1;
                    last_grant_d = 1'b1;
                    state_d      = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (op_q)
                    OP_LOAD: begin
                        count_d = rem_q;
                        state_d = ST_DONE;
                    end
                    OP_CLEAR: begin
                        count_d = '0;
                        state_d = ST_DONE;
                    end
                    default: begin
                        // UP/DOWN: one step per cycle; a zero step count still
                        // spends one EXEC cycle with the count held.
                        if (rem_q != '0) begin
                            if (op_q == OP_UP) begin
                                count_d = count_q + WIDTH'(1);
                            end else begin
                                count_d = count_q - WIDTH'(1);
                            end
                            rem_d = rem_q - WIDTH'(1);
                        end
                        if (rem_q <= WIDTH'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                endcase
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next-state value so they line up
    // with the state they describe.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        done_valid_d = (state_d == ST_DONE);
        done_id_d    = (state_d == ST_DONE) ? id_q : done_id_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LOAD;
            rem_q        <= '0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            count_q      <= '0;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b0;
            done_id_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rem_q        <= rem_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            busy_q       <= busy_d;
            done_valid_q <= done_valid_d;
            done_id_q    <= done_id_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.count      = count_q;
    assign bus.busy       = busy_q;
    assign bus.done_valid = done_valid_q;
    assign bus.done_id    = done_id_q;
endmodule

// File: tb/tb_count_cmd_scheduler.sv
// tb/tb_count_cmd_scheduler.sv - self-checking bench for count_cmd_scheduler
module tb_count_cmd_scheduler;
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic clk;
    logic rst;

    count_cmd_scheduler_if #(.WIDTH(8)) bus ();

    count_cmd_scheduler #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    typedef struct {
        logic       id;
        logic [1:0] op;
        logic [7:0] arg;
        logic [7:0] exp_count;
        int         exp_lat;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input logic id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    // Present one command and wait for its handshake; returns just after the
    // handshake edge with valid dropped.
    task automatic wait_handshake(input logic id, input logic [1:0] op, input logic [7:0] arg,
                                  output logic ok);
        ok = 1'b0;
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_arg = arg;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_arg = arg;
        end
        #1;
        for (int k = 0; k < 20; k++) begin
            if (rdy(id)) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    // Issue a command, measure edges from handshake to done_valid, then check
    // final count, done_id, latency, single-cycle pulse and return to idle.
    task automatic issue_cmd(input string name, input logic id, input logic [1:0] op,
                             input logic [7:0] arg, input logic [7:0] exp_count, input int exp_lat);
        logic ok;
        int   lat;
        logic seen_id;
        lat = -1;
        seen_id = 1'b0;
        wait_handshake(id, op, arg, ok);
        if (ok) begin
            for (int k = 1; k <= 300; k++) begin
                @(posedge clk);
                @(negedge clk);
                if (bus.done_valid) begin
                    lat = k;
                    seen_id = bus.done_id;
                    break;
                end
            end
        end
        check({name, "_lat"},   lat,       exp_lat);
        check({name, "_count"}, bus.count, {24'd0, exp_count});
        check({name, "_id"},    seen_id,   {31'd0, id});
        @(negedge clk);
        check({name, "_pulse"}, bus.done_valid, 32'd0);
        check({name, "_idle"},  bus.busy,       32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ok;
        logic [7:0] exp3 [3];
        int         both_err, busy_err, ngrant, dv_seen;
        logic       grants [4];

        n_total = 0;
        n_pass  = 0;
        bus.req0_valid = 1'b0; bus.req0_op = OP_LOAD; bus.req0_arg = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_op = OP_LOAD; bus.req1_arg = 8'h00;

        vecs[0]  = '{1'b0, OP_LOAD,  8'h2D, 8'h2D, 1};
        vecs[1]  = '{1'b0, OP_LOAD,  8'hFE, 8'hFE, 1};
        vecs[2]  = '{1'b1, OP_UP,    8'h03, 8'h01, 3};
        vecs[3]  = '{1'b1, OP_DOWN,  8'h02, 8'hFF, 2};
        vecs[4]  = '{1'b0, OP_CLEAR, 8'h55, 8'h00, 1};
        vecs[5]  = '{1'b0, OP_LOAD,  8'h10, 8'h10, 1};
        vecs[6]  = '{1'b1, OP_DOWN,  8'h00, 8'h10, 1};
        vecs[7]  = '{1'b0, OP_UP,    8'h00, 8'h10, 1};
        vecs[8]  = '{1'b1, OP_UP,    8'h05, 8'h15, 5};
        vecs[9]  = '{1'b0, OP_DOWN,  8'h16, 8'hFF, 22};
        vecs[10] = '{1'b1, OP_LOAD,  8'h00, 8'h00, 1};
        vecs[11] = '{1'b0, OP_DOWN,  8'h01, 8'hFF, 1};
        vecs[12] = '{1'b1, OP_UP,    8'h01, 8'h00, 1};

        // Reset with clock running
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_count",   bus.count,      32'd0);
        check("rst_busy",    bus.busy,       32'd0);
        check("rst_done",    bus.done_valid, 32'd0);
        check("rst_done_id", bus.done_id,    32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_count", bus.count,      32'd0);
        check("post_rst_busy",  bus.busy,       32'd0);
        check("post_rst_done",  bus.done_valid, 32'd0);

        for (int i = 0; i < 13; i++) begin
            issue_cmd($sformatf("vec%0d", i), vecs[i].id, vecs[i].op, vecs[i].arg,
                      vecs[i].exp_count, vecs[i].exp_lat);
        end

        // Wrap through 0xFF on consecutive edges
        issue_cmd("wrap_load", 1'b0, OP_LOAD, 8'hFE, 8'hFE, 1);
        exp3[0] = 8'hFF; exp3[1] = 8'h00; exp3[2] = 8'h01;
        wait_handshake(1'b1, OP_UP, 8'd3, ok);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("wrap_step%0d_count", k), bus.count, {24'd0, exp3[k]});
            check($sformatf("wrap_step%0d_done", k), bus.done_valid, (k == 2) ? 32'd1 : 32'd0);
        end
        check("wrap_done_id", bus.done_id, 32'd1);
        @(negedge clk);
        check("wrap_pulse", bus.done_valid, 32'd0);

        // Both requesters hold LOAD: last winner was req1, so req0 goes first
        both_err = 0; busy_err = 0; ngrant = 0;
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_op = OP_LOAD; bus.req0_arg = 8'hA0;
        bus.req1_valid = 1'b1; bus.req1_op = OP_LOAD; bus.req1_arg = 8'hB1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (bus.req0_ready && bus.req1_ready) both_err++;
            if (bus.req0_ready || bus.req1_ready) begin
                if (bus.busy) busy_err++;
                grants[ngrant] = bus.req1_ready;
                ngrant++;
                if (ngrant == 4) break;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        check("tie_both_ready", both_err, 32'd0);
        check("tie_ready_busy", busy_err, 32'd0);
        check("tie_ngrant",     ngrant,   32'd4);
        if (ngrant == 4) begin
            check("tie_grant0", grants[0], 32'd0);
            check("tie_grant1", grants[1], 32'd1);
            check("tie_grant2", grants[2], 32'd0);
            check("tie_grant3", grants[3], 32'd1);
        end
        repeat (5) @(negedge clk);
        check("tie_final_count", bus.count, 32'hA0);

        // Reset in the middle of UP 10
        issue_cmd("mid_clear", 1'b0, OP_CLEAR, 8'h00, 8'h00, 1);
        wait_handshake(1'b0, OP_UP, 8'd10, ok);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_count4", bus.count, 32'h04);
        check("mid_busy",   bus.busy,  32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_count", bus.count,      32'd0);
        check("mid_rst_busy",  bus.busy,       32'd0);
        check("mid_rst_done",  bus.done_valid, 32'd0);
        dv_seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.done_valid) dv_seen++;
        end
        rst = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (bus.done_valid) dv_seen++;
        end
        check("mid_no_done",     dv_seen,   32'd0);
        check("mid_count_after", bus.count, 32'd0);
        issue_cmd("mid_load7", 1'b0, OP_LOAD, 8'h07, 8'h07, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
